// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register file writeback arbiter.
// Holds the FSM state enum, the data width and the register index width.
package regfile_wb_arbiter_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef enum logic {
        WBA_NORMAL,
        WBA_FORCE
    } wba_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, MDU request, decode query and register file port bundle.
// The master side is the WB stage/MDU/decode; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = regfile_wb_arbiter_pkg::XLEN
);
    import regfile_wb_arbiter_pkg::*;

    logic             pipe_valid_i;
    logic             pipe_ready_o;
    logic [REG_W-1:0] pipe_rd_i;
    logic [XLEN-1:0]  pipe_wdata_i;

    logic             mdu_valid_i;
    logic             mdu_ready_o;
    logic [REG_W-1:0] mdu_rd_i;
    logic [XLEN-1:0]  mdu_wdata_i;

    logic             mdu_issue_i;
    logic [REG_W-1:0] mdu_issue_rd_i;
    logic [REG_W-1:0] rs1_i;
    logic [REG_W-1:0] rs2_i;
    logic             rs1_busy_o;
    logic             rs2_busy_o;

    logic             rf_wen_o;
    logic [REG_W-1:0] rf_rd_o;
    logic [XLEN-1:0]  rf_wdata_o;

    modport master (
        output pipe_valid_i, pipe_rd_i, pipe_wdata_i,
        output mdu_valid_i, mdu_rd_i, mdu_wdata_i,
        output mdu_issue_i, mdu_issue_rd_i, rs1_i, rs2_i,
        input  pipe_ready_o, mdu_ready_o,
        input  rs1_busy_o, rs2_busy_o,
        input  rf_wen_o, rf_rd_o, rf_wdata_o
    );

    modport slave (
        input  pipe_valid_i, pipe_rd_i, pipe_wdata_i,
        input  mdu_valid_i, mdu_rd_i, mdu_wdata_i,
        input  mdu_issue_i, mdu_issue_rd_i, rs1_i, rs2_i,
        output pipe_ready_o, mdu_ready_o,
        output rs1_busy_o, rs2_busy_o,
        output rf_wen_o, rf_rd_o, rf_wdata_o
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy bit per architectural register with an MDU result outstanding.
// x0 is never busy; a set and clear of the same index in one cycle leaves it set.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             rs1_busy,
    output logic             rs2_busy
);

    localparam int NREG = 1 << REG_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_n;

    always_comb begin
        busy_n = busy_q;
        if (clr_en)
            busy_n[clr_idx] = 1'b0;
        if (set_en)
            busy_n[set_idx] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            busy_q <= '0;
        else
            busy_q <= busy_n;
    end

    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write port arbiter: WB stage priority, MDU anti-starvation.
// Define REGFILE_WB_SCOREBOARD_EN to add the MDU pending-result scoreboard.
module regfile_wb_arbiter #(
    parameter int XLEN       = regfile_wb_arbiter_pkg::XLEN,
    parameter int STARVE_MAX = 4
) (
    input logic                clock,
    input logic                reset,
    regfile_wb_arbiter_if.slave bus
);
    import regfile_wb_arbiter_pkg::*;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    wba_state_e       state_q;
    wba_state_e       state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic             pipe_grant;
    logic             mdu_grant;
    logic             wen_q;
    logic [REG_W-1:0] rd_q;
    logic [XLEN-1:0]  wdata_q;

    assign bus.pipe_ready_o = (state_q == WBA_NORMAL);
    assign bus.mdu_ready_o  = (state_q == WBA_FORCE) || !bus.pipe_valid_i;

    assign pipe_grant = bus.pipe_valid_i && bus.pipe_ready_o;
    assign mdu_grant  = bus.mdu_valid_i && bus.mdu_ready_o;

    always_comb begin
        cnt_n   = cnt_q;
        state_n = state_q;
        if (!bus.mdu_valid_i || mdu_grant)
            cnt_n = '0;
        else if (cnt_q != CNT_MAX)
            cnt_n = cnt_q + CNT_W'(1);
        unique case (state_q)
            WBA_NORMAL: if (cnt_n == CNT_MAX) state_n = WBA_FORCE;
            WBA_FORCE:  if (mdu_grant || !bus.mdu_valid_i) state_n = WBA_NORMAL;
            default:    state_n = WBA_NORMAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= WBA_NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Grants are mutually exclusive; x0 requests handshake without a write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wen_q   <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= 1'b0;
            if (pipe_grant) begin
                wen_q   <= |bus.pipe_rd_i;
                rd_q    <= bus.pipe_rd_i;
                wdata_q <= bus.pipe_wdata_i;
            end else if (mdu_grant) begin
                wen_q   <= |bus.mdu_rd_i;
                rd_q    <= bus.mdu_rd_i;
                wdata_q <= bus.mdu_wdata_i;
            end
        end
    end

    assign bus.rf_wen_o   = wen_q;
    assign bus.rf_rd_o    = rd_q;
    assign bus.rf_wdata_o = wdata_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    regfile_scoreboard u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (bus.mdu_issue_i && (|bus.mdu_issue_rd_i)),
        .set_idx  (bus.mdu_issue_rd_i),
        .clr_en   (mdu_grant),
        .clr_idx  (bus.mdu_rd_i),
        .rs1      (bus.rs1_i),
        .rs2      (bus.rs2_i),
        .rs1_busy (bus.rs1_busy_o),
        .rs2_busy (bus.rs2_busy_o)
    );
`else
    logic unused_sb;
    assign unused_sb = ^{bus.mdu_issue_i, bus.mdu_issue_rd_i, bus.rs1_i, bus.rs2_i};
    assign bus.rs1_busy_o = 1'b0;
    assign bus.rs2_busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (STARVE_MAX = 4).
// Busy expectations follow REGFILE_WB_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.XLEN(64), .STARVE_MAX(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset              = 1'b1;
        bus.pipe_valid_i   = 1'b0;
        bus.pipe_rd_i      = '0;
        bus.pipe_wdata_i   = '0;
        bus.mdu_valid_i    = 1'b0;
        bus.mdu_rd_i       = '0;
        bus.mdu_wdata_i    = '0;
        bus.mdu_issue_i    = 1'b0;
        bus.mdu_issue_rd_i = '0;
        bus.rs1_i          = '0;
        bus.rs2_i          = '0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("rst_pipe_ready", bus.pipe_ready_o, 1);
        check("rst_mdu_ready", bus.mdu_ready_o, 1);
        check("rst_wen", bus.rf_wen_o, 0);
        check("rst_rd", bus.rf_rd_o, 0);
        check("rst_wdata", bus.rf_wdata_o, 0);

        // pipeline-only write
        tick();
        bus.pipe_valid_i = 1'b1;
        bus.pipe_rd_i    = 5'd5;
        bus.pipe_wdata_i = 64'hDEAD;
        #1;
        check("pipe_ready", bus.pipe_ready_o, 1);
        check("pipe_blocks_mdu", bus.mdu_ready_o, 0);
        tick();
        bus.pipe_valid_i = 1'b0;
        check("pipe_wen", bus.rf_wen_o, 1);
        check("pipe_rd", bus.rf_rd_o, 5);
        check("pipe_wdata", bus.rf_wdata_o, 64'hDEAD);
        tick();
        check("idle_wen", bus.rf_wen_o, 0);

        // starvation: pipe held, MDU stalled four cycles then forced
        bus.pipe_valid_i = 1'b1;
        bus.pipe_rd_i    = 5'd1;
        bus.pipe_wdata_i = 64'h1;
        bus.mdu_valid_i  = 1'b1;
        bus.mdu_rd_i     = 5'd7;
        bus.mdu_wdata_i  = 64'h77;
        #1;
        check("starve_mdu_ready0", bus.mdu_ready_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("starve_pipe_rd", bus.rf_rd_o, 1);
            check("starve_mdu_ready", bus.mdu_ready_o, (i == 3) ? 1 : 0);
            check("starve_pipe_ready", bus.pipe_ready_o, (i == 3) ? 0 : 1);
        end
        tick();
        check("force_wen", bus.rf_wen_o, 1);
        check("force_rd", bus.rf_rd_o, 7);
        check("force_wdata", bus.rf_wdata_o, 64'h77);
        bus.mdu_valid_i = 1'b0;
        #1;
        check("back_normal", bus.pipe_ready_o, 1);
        tick();
        check("pipe_resume_rd", bus.rf_rd_o, 1);

        // counter clears when MDU valid drops
        bus.mdu_valid_i = 1'b1;
        bus.mdu_rd_i    = 5'd8;
        bus.mdu_wdata_i = 64'h88;
        repeat (2) tick();
        bus.mdu_valid_i = 1'b0;
        tick();
        bus.mdu_valid_i = 1'b1;
        repeat (3) tick();
        check("cnt_cleared", bus.mdu_ready_o, 0);
        tick();
        check("cnt_force", bus.mdu_ready_o, 1);
        tick();
        check("cnt_force_rd", bus.rf_rd_o, 8);
        bus.mdu_valid_i  = 1'b0;
        bus.pipe_valid_i = 1'b0;
        tick();

        // scoreboard set, no clear bypass, clear after grant
        bus.mdu_issue_i    = 1'b1;
        bus.mdu_issue_rd_i = 5'd9;
        bus.rs1_i          = 5'd9;
        bus.rs2_i          = 5'd9;
        #1;
        check("sb_not_yet", bus.rs1_busy_o, 0);
        tick();
        bus.mdu_issue_i = 1'b0;
        check("sb_rs1_busy9", bus.rs1_busy_o, SB);
        check("sb_rs2_busy9", bus.rs2_busy_o, SB);
        bus.rs2_i = 5'd10;
        #1;
        check("sb_rs2_idle10", bus.rs2_busy_o, 0);
        bus.mdu_valid_i = 1'b1;
        bus.mdu_rd_i    = 5'd9;
        bus.mdu_wdata_i = 64'h99;
        #1;
        check("sb_mdu_ready", bus.mdu_ready_o, 1);
        check("sb_no_bypass", bus.rs1_busy_o, SB);
        tick();
        bus.mdu_valid_i = 1'b0;
        check("sb_grant_rd", bus.rf_rd_o, 9);
        check("sb_cleared9", bus.rs1_busy_o, 0);

        // same-cycle set and clear: set wins
        bus.mdu_issue_i    = 1'b1;
        bus.mdu_issue_rd_i = 5'd3;
        bus.rs1_i          = 5'd3;
        tick();
        bus.mdu_valid_i = 1'b1;
        bus.mdu_rd_i    = 5'd3;
        tick();
        bus.mdu_issue_i = 1'b0;
        bus.mdu_valid_i = 1'b0;
        check("sb_set_wins", bus.rs1_busy_o, SB);
        check("sb_set_wins_wen", bus.rf_wen_o, 1);
        bus.mdu_valid_i = 1'b1;
        tick();
        bus.mdu_valid_i = 1'b0;
        check("sb_cleared3", bus.rs1_busy_o, 0);

        // rd=0 requests from both sources
        bus.mdu_issue_i    = 1'b1;
        bus.mdu_issue_rd_i = 5'd12;
        tick();
        bus.mdu_issue_i = 1'b0;
        bus.rs1_i       = 5'd12;
        check("sb_busy12", bus.rs1_busy_o, SB);
        bus.pipe_valid_i = 1'b1;
        bus.pipe_rd_i    = 5'd0;
        bus.pipe_wdata_i = 64'h55;
        #1;
        check("x0_pipe_ready", bus.pipe_ready_o, 1);
        tick();
        bus.pipe_valid_i = 1'b0;
        check("x0_pipe_wen", bus.rf_wen_o, 0);
        check("x0_pipe_rd", bus.rf_rd_o, 0);
        bus.mdu_valid_i = 1'b1;
        bus.mdu_rd_i    = 5'd0;
        #1;
        check("x0_mdu_ready", bus.mdu_ready_o, 1);
        tick();
        bus.mdu_valid_i = 1'b0;
        check("x0_mdu_wen", bus.rf_wen_o, 0);
        check("x0_sb_kept12", bus.rs1_busy_o, SB);
        bus.mdu_issue_i    = 1'b1;
        bus.mdu_issue_rd_i = 5'd0;
        bus.rs2_i          = 5'd0;
        tick();
        bus.mdu_issue_i = 1'b0;
        check("x0_never_busy", bus.rs2_busy_o, 0);

        // asynchronous reset mid-cycle while in FORCE with a write in flight
        bus.pipe_valid_i = 1'b1;
        bus.pipe_rd_i    = 5'd4;
        bus.pipe_wdata_i = 64'h44;
        bus.mdu_valid_i  = 1'b1;
        bus.mdu_rd_i     = 5'd6;
        repeat (4) tick();
        check("pre_rst_force", bus.pipe_ready_o, 0);
        check("pre_rst_wen", bus.rf_wen_o, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_wen", bus.rf_wen_o, 0);
        check("arst_rd", bus.rf_rd_o, 0);
        check("arst_wdata", bus.rf_wdata_o, 0);
        check("arst_pipe_ready", bus.pipe_ready_o, 1);
        check("arst_mdu_ready", bus.mdu_ready_o, 0);
        check("arst_busy", bus.rs1_busy_o, 0);
        tick();
        reset            = 1'b0;
        bus.pipe_valid_i = 1'b0;
        bus.mdu_valid_i  = 1'b0;
        tick();
        check("post_rst_wen", bus.rf_wen_o, 0);
        check("post_rst_busy", bus.rs1_busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
